// File: rtl/icache_axi_refill_if.sv
// Bundle of cache miss-path and AXI3 read-channel signals between the I-cache,
// the refill engine (master modport) and the memory side (slave modport).
interface icache_axi_refill_if #(
  parameter int OFFSET_LEN = 5
);
  localparam int WORDS = 1 << (OFFSET_LEN - 2);

  logic                   mem_read_req;
  logic [31:0]            mem_addr;
  logic                   mem_gnt;
  logic [WORDS-1:0][31:0] ins;
  logic                   refill_err;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  mem_read_req, mem_addr, arready, rdata, rresp, rlast, rvalid,
    output mem_gnt, ins, refill_err, arid, araddr, arlen, arsize, arburst,
           arlock, arcache, arprot, arvalid, rready
  );

  modport slave (
    output mem_read_req, mem_addr, arready, rdata, rresp, rlast, rvalid,
    input  mem_gnt, ins, refill_err, arid, araddr, arlen, arsize, arburst,
           arlock, arcache, arprot, arvalid, rready
  );
endinterface

// File: rtl/icache_axi_refill.sv
// I-cache line refill engine: one AXI3 INCR burst per miss, beats assembled into
// a registered line, handed back with a single-cycle grant (plus error flag).
module icache_axi_refill #(
  parameter int         OFFSET_LEN = 5,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  icache_axi_refill_if.master bus
);
  localparam int WORDS = 1 << (OFFSET_LEN - 2);
  localparam int BW    = $clog2(WORDS) + 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DONE, S_HOLD} state_t;

  state_t r_state, w_next_state;

  logic r_arvalid, w_arvalid_next;
  logic r_rready, w_rready_next;
  logic r_mem_gnt, w_mem_gnt_next;
  logic r_refill_err, w_refill_err_next;

  logic [31:0]    r_araddr;
  logic [BW-1:0]  r_beat;
  logic           r_err;
  logic [31:0]    r_ins [WORDS];
  logic [WORDS-1:0][31:0] w_ins;

  logic          w_beat_fire;
  logic          w_room;
  logic          w_beat_err;
  logic [BW-1:0] w_count_final;
  logic          w_err_final;

  // Only the line-aligned part of the request address is used.
  wire w_unused = &{1'b0, bus.mem_addr[OFFSET_LEN-1:0]};

  assign w_beat_fire   = (r_state == S_R) && bus.rvalid;
  assign w_room        = (r_beat < BW'(WORDS));
  assign w_beat_err    = (bus.rresp != 2'b00) || !w_room;
  assign w_count_final = w_room ? (r_beat + BW'(1)) : r_beat;
  // Error state including the beat accepted this cycle and the final count check.
  assign w_err_final   = r_err || w_beat_err || (w_count_final != BW'(WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_mem_gnt    <= 1'b0;
      r_refill_err <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_arvalid    <= w_arvalid_next;
      r_rready     <= w_rready_next;
      r_mem_gnt    <= w_mem_gnt_next;
      r_refill_err <= w_refill_err_next;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_arvalid_next    = 1'b0;
    w_rready_next     = 1'b0;
    w_mem_gnt_next    = 1'b0;
    w_refill_err_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_read_req) begin
          w_next_state   = S_AR;
          w_arvalid_next = 1'b1;
        end
      end
      S_AR: begin
        if (bus.arready) begin
          w_next_state  = S_R;
          w_rready_next = 1'b1;
        end else begin
          w_arvalid_next = 1'b1;
        end
      end
      S_R: begin
        // Completion follows rlast alone; short or long bursts just flag an error.
        if (w_beat_fire && bus.rlast) begin
          w_next_state      = S_DONE;
          w_mem_gnt_next    = bus.mem_read_req;
          w_refill_err_next = bus.mem_read_req && w_err_final;
        end else begin
          w_rready_next = 1'b1;
        end
      end
      S_DONE: w_next_state = S_HOLD;
      S_HOLD: begin
        if (!bus.mem_read_req) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= 32'd0;
      r_beat   <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && bus.mem_read_req) begin
        r_araddr <= {bus.mem_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
        r_beat   <= '0;
        r_err    <= 1'b0;
      end
      if (w_beat_fire) begin
        if (w_room) begin
          r_beat <= r_beat + BW'(1);
        end
        if (w_beat_err) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Each line word captures only its own beat, so untouched words keep old data.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ins[gi] <= 32'd0;
        end else if (w_beat_fire && (r_beat == BW'(gi))) begin
          r_ins[gi] <= bus.rdata;
        end
      end
    end
  endgenerate

  always_comb begin
    w_ins = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_ins[i] = r_ins[i];
    end
  end

  assign bus.ins        = w_ins;
  assign bus.mem_gnt    = r_mem_gnt;
  assign bus.refill_err = r_refill_err;
  assign bus.arvalid    = r_arvalid;
  assign bus.rready     = r_rready;
  assign bus.araddr     = r_araddr;
  assign bus.arid       = AXI_ID;
  assign bus.arlen      = 4'(WORDS - 1);
  assign bus.arsize     = 3'b010;
  assign bus.arburst    = 2'b01;
  assign bus.arlock     = 2'b00;
  assign bus.arcache    = 4'b0000;
  assign bus.arprot     = 3'b000;
endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: a hand-driven AXI read slave and cache
// requester, with expected line contents and handshake timing written out per step.
module tb_icache_axi_refill;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   lat;
  logic [31:0] exp_ins [8];

  icache_axi_refill_if #(.OFFSET_LEN(5)) bus ();

  icache_axi_refill #(.OFFSET_LEN(5), .AXI_ID(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_line(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_ins%0d", tag, i), bus.ins[i], exp_ins[i]);
    end
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int i = 0; i < 8; i++) exp_ins[i] = base + 32'(i);
  endtask

  // Waits (bounded) for arvalid, checks the address, stalls arready, then accepts.
  task automatic ar_phase(input string tag, input logic [31:0] exp_addr,
                          input int stall, output int n);
    n = 0;
    while (!bus.arvalid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_arvalid_up"}, 32'(bus.arvalid), 32'd1);
    chk({tag, "_araddr"}, bus.araddr, exp_addr);
    repeat (stall) tick();
    if (stall > 0) chk({tag, "_arvalid_held"}, 32'(bus.arvalid), 32'd1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk({tag, "_arvalid_drop"}, 32'(bus.arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(bus.rready), 32'd1);
  endtask

  // Beat k carries base+k; vpat bit c says whether cycle c carries a beat.
  task automatic r_beats(input logic [31:0] base, input int nbeats, input int err_beat,
                         input logic [31:0] vpat, input bit do_last);
    int sent = 0;
    int c = 0;
    while (sent < nbeats && c < 64) begin
      if (vpat[c % 32]) begin
        bus.rvalid = 1'b1;
        bus.rdata  = base + 32'(sent);
        bus.rresp  = (sent == err_beat) ? 2'b10 : 2'b00;
        bus.rlast  = do_last && (sent == nbeats - 1);
        sent++;
      end else begin
        bus.rvalid = 1'b0;
        bus.rdata  = 32'hDEAD_0000 | 32'(c);
        bus.rresp  = 2'b00;
        bus.rlast  = 1'b0;
      end
      tick();
      c++;
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  task automatic finish_req();
    bus.mem_read_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.mem_read_req = 1'b0;
    bus.mem_addr     = 32'd0;
    bus.arready      = 1'b0;
    bus.rdata        = 32'd0;
    bus.rresp        = 2'b00;
    bus.rlast        = 1'b0;
    bus.rvalid       = 1'b0;
    tick();
    tick();
    set_line(32'd0);
    for (int i = 0; i < 8; i++) exp_ins[i] = 32'd0;
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_rready", 32'(bus.rready), 32'd0);
    chk("rst_gnt", 32'(bus.mem_gnt), 32'd0);
    chk("rst_err", 32'(bus.refill_err), 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk_line("rst");
    chk("const_arlen", 32'(bus.arlen), 32'd7);
    chk("const_arsize", 32'(bus.arsize), 32'd2);
    chk("const_arburst", 32'(bus.arburst), 32'd1);
    chk("const_arid", 32'(bus.arid), 32'd0);
    chk("const_lock_cache_prot", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
    rst = 1'b0;
    tick();

    // Basic fill
    bus.mem_addr = 32'h1FC0_0024;
    bus.mem_read_req = 1'b1;
    ar_phase("t1", 32'h1FC0_0020, 2, lat);
    chk("t1_ar_latency", 32'(lat), 32'd1);
    r_beats(32'hA0, 8, -1, 32'hFFFF_FFFF, 1'b1);
    set_line(32'hA0);
    chk("t1_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("t1_err", 32'(bus.refill_err), 32'd0);
    chk_line("t1");
    tick();
    chk("t1_gnt_pulse", 32'(bus.mem_gnt), 32'd0);
    finish_req();
    tick();
    chk("t1_idle_no_ar", 32'(bus.arvalid), 32'd0);

    // Throttled R channel (valid pattern 1,0,0,1,...)
    bus.mem_addr = 32'h0000_0100;
    bus.mem_read_req = 1'b1;
    ar_phase("t2", 32'h0000_0100, 0, lat);
    r_beats(32'hB0, 8, -1, 32'h9999_9999, 1'b1);
    set_line(32'hB0);
    chk("t2_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("t2_err", 32'(bus.refill_err), 32'd0);
    chk_line("t2");
    finish_req();

    // Error response on beat 3
    bus.mem_addr = 32'h0000_0200;
    bus.mem_read_req = 1'b1;
    ar_phase("t3", 32'h0000_0200, 1, lat);
    r_beats(32'hC0, 8, 3, 32'hFFFF_FFFF, 1'b1);
    set_line(32'hC0);
    chk("t3_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("t3_err", 32'(bus.refill_err), 32'd1);
    chk_line("t3");
    finish_req();

    // Short burst: rlast on 5th beat, words 5..7 keep previous line
    bus.mem_addr = 32'h0000_0300;
    bus.mem_read_req = 1'b1;
    ar_phase("t4", 32'h0000_0300, 0, lat);
    r_beats(32'hD0, 5, -1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 5; i++) exp_ins[i] = 32'hD0 + 32'(i);
    chk("t4_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("t4_err", 32'(bus.refill_err), 32'd1);
    chk_line("t4");
    finish_req();

    // Request held after grant, then a new request with a new address
    bus.mem_addr = 32'h0000_0400;
    bus.mem_read_req = 1'b1;
    ar_phase("t5", 32'h0000_0400, 0, lat);
    r_beats(32'hE0, 8, -1, 32'hFFFF_FFFF, 1'b1);
    chk("t5_gnt", 32'(bus.mem_gnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_held%0d_arvalid", k), 32'(bus.arvalid), 32'd0);
      chk($sformatf("t5_held%0d_gnt", k), 32'(bus.mem_gnt), 32'd0);
    end
    finish_req();
    bus.mem_addr = 32'h0000_1234;
    bus.mem_read_req = 1'b1;
    ar_phase("t5b", 32'h0000_1220, 0, lat);
    r_beats(32'h10, 8, -1, 32'hFFFF_FFFF, 1'b1);
    set_line(32'h10);
    chk("t5b_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("t5b_err", 32'(bus.refill_err), 32'd0);
    chk_line("t5b");
    finish_req();

    // Reset in the middle of the data phase
    bus.mem_addr = 32'h8000_0040;
    bus.mem_read_req = 1'b1;
    ar_phase("t6", 32'h8000_0040, 0, lat);
    r_beats(32'h50, 4, -1, 32'hFFFF_FFFF, 1'b0);
    rst = 1'b1;
    bus.mem_read_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_ins[i] = 32'd0;
    chk("t6_rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("t6_rst_rready", 32'(bus.rready), 32'd0);
    chk("t6_rst_gnt", 32'(bus.mem_gnt), 32'd0);
    chk("t6_rst_araddr", bus.araddr, 32'd0);
    chk_line("t6_rst");
    bus.mem_addr = 32'h0000_0040;
    bus.mem_read_req = 1'b1;
    ar_phase("t6b", 32'h0000_0040, 0, lat);
    chk("t6b_ar_latency", 32'(lat), 32'd1);
    r_beats(32'h60, 8, -1, 32'hFFFF_FFFF, 1'b1);
    set_line(32'h60);
    chk("t6b_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("t6b_err", 32'(bus.refill_err), 32'd0);
    chk_line("t6b");
    finish_req();

    // Long burst: 9 beats, extra beat discarded and flagged
    bus.mem_addr = 32'h0000_0500;
    bus.mem_read_req = 1'b1;
    ar_phase("t7", 32'h0000_0500, 0, lat);
    r_beats(32'h70, 9, -1, 32'hFFFF_FFFF, 1'b1);
    set_line(32'h70);
    chk("t7_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("t7_err", 32'(bus.refill_err), 32'd1);
    chk_line("t7");
    finish_req();

    // Request withdrawn during the burst: burst drains, no grant
    bus.mem_addr = 32'h0000_0600;
    bus.mem_read_req = 1'b1;
    ar_phase("t8", 32'h0000_0600, 0, lat);
    bus.mem_read_req = 1'b0;
    r_beats(32'h90, 8, -1, 32'hFFFF_FFFF, 1'b1);
    chk("t8_no_gnt", 32'(bus.mem_gnt), 32'd0);
    chk("t8_no_err", 32'(bus.refill_err), 32'd0);
    chk("t8_ins0", bus.ins[0], 32'h90);
    tick();
    tick();
    tick();
    chk("t8_idle_arvalid", 32'(bus.arvalid), 32'd0);
    chk("t8_idle_gnt", 32'(bus.mem_gnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
Refill engine directly downstream of the instruction cache miss path.
- Accepts a line-fill request (mem_read_req / mem_addr) from the I-cache.
- Issues one AXI3 INCR read burst of 8 × 32-bit beats and assembles the beats into an 8-word line.
- Returns the line to the cache's bank write ports with a one-cycle mem_gnt pulse.

Parameters:
OFFSET_LEN, 5, log2 line bytes; words per line = 1<<(OFFSET_LEN-2) = 8
AXI_ID, 4'd0, constant arid driven on every burst

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mem_read_req  input  1  line-fill request from cache, held high until gnt observed
mem_addr  input  32  line address (low OFFSET_LEN bits zero)
mem_gnt  output  1  one-cycle pulse: ins[] complete and valid
ins  output  32×8  assembled line, word i = beat i
refill_err  output  1  pulses with mem_gnt if any rresp≠OKAY or beat count≠8
arid  output  4  = AXI_ID
araddr  output  32  latched line address
arlen  output  4  = 4'd7
arsize/arburst  output  3/2  = 3'b010 / 2'b01 (INCR)
arlock/arcache/arprot  output  2/4/3  all zero
arvalid  output  1  address valid
arready  input  1  address accept
rdata  input  32  read data
rresp  input  2  read response
rlast  input  1  last beat
rvalid  input  1  data valid
rready  output  1  data accept

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state←IDLE; arvalid, rready, mem_gnt, refill_err←0.
  - beat counter←0; ins[0..7]←0; araddr←0.
  - An in-flight AXI burst is abandoned; the interconnect is reset by the same rst.
- States: IDLE, AR, R, DONE, HOLD.
- IDLE: on mem_read_req=1, latch araddr←{mem_addr[31:OFFSET_LEN], 0}, clear beat counter and error flag, go AR (next cycle arvalid=1).
- AR:
  - arvalid=1; araddr stable.
  - On arready=1 at posedge, go R. arvalid drops that edge; no combinational dependency of arvalid on arready.
- R:
  - rready=1.
  - Each posedge with rvalid=1:
    - if beat<8, ins[beat]←rdata and beat←beat+1.
    - beats beyond the 8th are discarded and set the error flag.
    - rresp≠2'b00 sets the error flag.
  - rvalid&rlast: if the final count≠8, set the error flag; go DONE.
  - Completion is keyed on rlast only, never on the count.
- DONE:
  - If mem_read_req=1: mem_gnt=1 and refill_err=flag, both for exactly this cycle.
  - If mem_read_req=0 (request withdrawn mid-burst): no gnt.
  - Always go HOLD.
- HOLD: wait until mem_read_req=0, then IDLE. This prevents re-launching on the still-high request in the cycle after gnt.
- Data hold: ins[] is registered and remains stable from the DONE cycle until the next burst's first accepted beat. The cache writes its banks in the cycle after gnt.
- Latency: request to arvalid = 1 cycle. Last beat to mem_gnt = 1 cycle. Minimum miss = 1 + AR wait + 8 beats + 1.
- Request withdrawal: once arvalid is raised, it stays high until arready. The burst always drains to rlast; the AXI protocol is never violated.
- Single outstanding transaction; rid is ignored.
- All outputs are registered except the constant AR fields.

Test Plan:
- Basic fill: req addr 0x1FC0_0024, arready after 2 cycles, 8 back-to-back beats 0xA0..0xA7 with rlast on the 8th → araddr=0x1FC0_0020, arlen=7, ins[i]=0xA0+i, mem_gnt pulse 1 cycle after rlast, refill_err=0, return to IDLE after req drops.
- Throttled R channel: rvalid gaps (1,0,0,1,…) → only valid beats are captured in order; gnt timing is tied to rlast; ins matches beats.
- Error response: beat 3 has rresp=2'b10 → data is still captured; refill_err=1 coincident with mem_gnt.
- Short burst: rlast on beat 5 → DONE entered; ins[5..7] keep old values; refill_err=1.
- Req held after gnt: mem_read_req stays high 3 cycles past gnt → no second arvalid; a new req after deassertion starts a new burst with the new address.
- Reset mid-R (after 4 beats) → next cycle arvalid=rready=mem_gnt=0, ins all 0, state IDLE; a subsequent req launches a clean burst.
